// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state, the transaction owner and the streak width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  function automatic int streak_w(input int max_b);
    return (max_b < 1) ? 1 : $clog2(max_b + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_fair_picker.sv
// Winner select between fetch and data requests.
// Data side wins unless it has starved fetch for MAX_D_BURST grants.
module arb_fair_picker
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_BURST = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

  localparam int SW = streak_w(MAX_D_BURST);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_BURST);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          i_wins;

  assign i_wins  = i_req_i && (!d_req_i || (streak_q == SMAX));
  assign i_gnt_o = en_i && i_wins;
  assign d_gnt_o = en_i && d_req_i && !i_wins;

  // Streak only counts data grants that actually made fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (!i_req_i || i_gnt_o) begin
      streak_d = '0;
    end else if (d_gnt_o && (streak_q != SMAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port memory.
// One transaction in flight; response routed back to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wstrb,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic [AW-1:0]   m_addr,
  output logic            m_we,
  output logic [DW/8-1:0] m_wstrb,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  localparam int BW = DW / 8;

  state_e          state_q, state_d;
  owner_e          own_q, own_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [BW-1:0]   strb_q, strb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            i_rv_q, i_rv_d;
  logic            d_rv_q, d_rv_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;

  logic pick_i;
  logic pick_d;
  logic arb_en;
  logic in_req;
  logic resp_fire;

  // Grants stay low while reset is held, even in IDLE.
  assign arb_en = (state_q == IDLE) && reset_n;
  assign in_req = (state_q == REQ);

  arb_fair_picker #(
    .MAX_D_BURST(MAX_D_BURST)
  ) u_picker (
    .clk     (clk),
    .rst_n   (reset_n),
    .en_i    (arb_en),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .i_gnt_o (pick_i),
    .d_gnt_o (pick_d)
  );

  assign resp_fire = (in_req && m_gnt && m_rvalid)
                  || ((state_q == RESP) && m_rvalid);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_i || pick_d) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (m_gnt) begin
          state_d = m_rvalid ? IDLE : RESP;
        end
      end
      RESP: begin
        if (m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetches carry no write payload onto the memory bus.
  always_comb begin
    own_d   = own_q;
    addr_d  = addr_q;
    we_d    = we_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      pick_d: begin
        own_d   = OWN_D;
        addr_d  = d_addr;
        we_d    = d_we;
        strb_d  = d_wstrb;
        wdata_d = d_wdata;
      end
      pick_i: begin
        own_d   = OWN_I;
        addr_d  = i_addr;
        we_d    = 1'b0;
        strb_d  = '0;
        wdata_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Write acknowledges return zero data.
  always_comb begin
    i_rv_d    = 1'b0;
    d_rv_d    = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (resp_fire) begin
      if (own_q == OWN_I) begin
        i_rv_d    = 1'b1;
        i_rdata_d = m_rdata;
      end else begin
        d_rv_d    = 1'b1;
        d_rdata_d = we_q ? '0 : m_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      own_q     <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      i_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      i_rv_q    <= i_rv_d;
      d_rv_q    <= d_rv_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_gnt    = pick_i;
  assign d_gnt    = pick_d;
  assign i_rvalid = i_rv_q;
  assign d_rvalid = d_rv_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign m_req   = in_req;
  assign m_addr  = in_req ? addr_q  : '0;
  assign m_we    = in_req ? we_q    : 1'b0;
  assign m_wstrb = in_req ? strb_q  : '0;
  assign m_wdata = in_req ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder, response scoreboard,
// one task per scenario.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [BW-1:0] d_wstrb;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [BW-1:0] m_wstrb;
  logic [DW-1:0] m_wdata;
  logic          m_gnt;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  mem_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_D_BURST(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wstrb  (d_wstrb),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_wstrb  (m_wstrb),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_i;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_pop;
  int   n_chk  = 0;
  int   n_fail = 0;

  int gnt_delay = 0;
  int rv_lat    = 1;
  int ph        = 0;
  int wcnt      = 0;
  int lcnt      = 0;
  logic [DW-1:0] pend;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a,
                                          input logic we);
    if (we) return 32'hBAD0_BAD0;
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory responder: gnt after gnt_delay cycles, rvalid rv_lat later.
  initial begin
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    pend = '0;
    forever begin
      @(posedge clk);
      #1;
      m_gnt = 1'b0;
      m_rvalid = 1'b0;
      m_rdata = '0;
      if (ph == 0) begin
        if (m_req) begin
          if (wcnt >= gnt_delay) begin
            m_gnt = 1'b1;
            wcnt = 0;
            pend = memfn(m_addr, m_we);
            if (rv_lat == 0) begin
              m_rvalid = 1'b1;
              m_rdata = pend;
            end else begin
              ph = 1;
              lcnt = 1;
            end
          end else begin
            wcnt++;
          end
        end
      end else begin
        if (lcnt >= rv_lat) begin
          m_rvalid = 1'b1;
          m_rdata = pend;
          ph = 0;
        end else begin
          lcnt++;
        end
      end
    end
  end

  // Response scoreboard and grant exclusivity monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        n_chk++;
        if (i_gnt && d_gnt) begin
          n_fail++;
          $display("FAIL gnt_excl: i_gnt=%b d_gnt=%b, required one", i_gnt, d_gnt);
        end
      end
      if (i_rvalid || d_rvalid) begin
        n_chk++;
        if (i_rvalid && d_rvalid) begin
          n_fail++;
          $display("FAIL rvalid_excl: both rvalid high, required one");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid_unexp: i_rvalid=%b d_rvalid=%b, required none",
                   i_rvalid, d_rvalid);
        end else begin
          e_pop = exp_q.pop_front();
          if ({i_rvalid, (i_rvalid ? i_rdata : d_rdata)} !== {e_pop.is_i, e_pop.data}) begin
            n_fail++;
            $display("FAIL resp: got is_i=%b data=%h, required is_i=%b data=%h",
                     i_rvalid, (i_rvalid ? i_rdata : d_rdata), e_pop.is_i, e_pop.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    smp();
    n_chk++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, m_wstrb,
         m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: gnt=%b%b rv=%b%b m_req=%b m_addr=%h, required all 0",
               i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_addr);
    end
    tick();
  endtask

  task automatic test_single_fetch();
    int lat;
    gnt_delay = 0;
    rv_lat = 2;
    i_req = 1'b1;
    i_addr = 32'h100;
    smp();
    n_chk++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b, required 1 0", i_gnt, d_gnt);
    end
    exp_q.push_back(exp_t'{1'b1, 32'h0050_0093});
    tick();
    i_req = 1'b0;
    i_addr = 32'h0;
    smp();
    n_chk++;
    if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL fetch_mreq: m_req=%b m_we=%b m_addr=%h, required 1 0 00000100",
               m_req, m_we, m_addr);
    end
    lat = 1;
    while (!i_rvalid && lat < 20) begin
      tick();
      smp();
      lat++;
    end
    n_chk++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL fetch_latency: i_rvalid at cycle %0d, required 4", lat);
    end
    drain("fetch");
  endtask

  task automatic test_simultaneous();
    int k;
    bit saw_d;
    gnt_delay = 1;
    rv_lat = 1;
    i_req = 1'b1;
    i_addr = 32'h104;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h2000;
    d_wstrb = '0;
    d_wdata = '0;
    smp();
    n_chk++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_first: i_gnt=%b d_gnt=%b, required 0 1", i_gnt, d_gnt);
    end
    exp_q.push_back(exp_t'{1'b0, memfn(32'h2000, 1'b0)});
    tick();
    d_req = 1'b0;
    saw_d = 1'b0;
    k = 0;
    smp();
    while (!i_gnt && k < 30) begin
      if (d_rvalid) saw_d = 1'b1;
      tick();
      smp();
      k++;
    end
    if (d_rvalid) saw_d = 1'b1;
    n_chk++;
    if (i_gnt !== 1'b1 || !saw_d) begin
      n_fail++;
      $display("FAIL simul_second: i_gnt=%b d_done=%b, required 1 1", i_gnt, saw_d);
    end
    if (i_gnt) exp_q.push_back(exp_t'{1'b1, memfn(32'h104, 1'b0)});
    tick();
    i_req = 1'b0;
    drain("simul");
  endtask

  task automatic test_burst_order();
    string seq;
    int n;
    int k;
    gnt_delay = 0;
    rv_lat = 1;
    seq = "";
    n = 0;
    k = 0;
    i_req = 1'b1;
    i_addr = 32'h200;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h2100;
    while (n < 6 && k < 100) begin
      smp();
      if (i_gnt) begin
        seq = {seq, "I"};
        exp_q.push_back(exp_t'{1'b1, memfn(32'h200, 1'b0)});
        n++;
      end else if (d_gnt) begin
        seq = {seq, "D"};
        exp_q.push_back(exp_t'{1'b0, memfn(32'h2100, 1'b0)});
        n++;
      end
      tick();
      k++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    n_chk++;
    if (seq != "DDIDDI") begin
      n_fail++;
      $display("FAIL burst_order: got %s, required DDIDDI", seq);
    end
    drain("burst");
  endtask

  task automatic test_write_stall();
    int cyc;
    gnt_delay = 3;
    rv_lat = 1;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h2004;
    d_wstrb = 4'b0011;
    d_wdata = 32'hDEAD_BEEF;
    smp();
    n_chk++;
    if (d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_gnt: d_gnt=%b, required 1", d_gnt);
    end
    exp_q.push_back(exp_t'{1'b0, 32'h0});
    tick();
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = 32'hFFFF_FFFF;
    d_wstrb = 4'hF;
    d_wdata = 32'h0;
    smp();
    cyc = 0;
    while (m_req && cyc < 20) begin
      n_chk++;
      if ({m_addr, m_we, m_wstrb, m_wdata} !==
          {32'h2004, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin
        n_fail++;
        $display("FAIL wr_fields: addr=%h we=%b strb=%b data=%h, required 00002004 1 0011 deadbeef",
                 m_addr, m_we, m_wstrb, m_wdata);
      end
      cyc++;
      tick();
      smp();
    end
    n_chk++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL wr_stall_len: m_req held %0d cycles, required 4", cyc);
    end
    drain("write");
  endtask

  task automatic test_zero_latency();
    gnt_delay = 0;
    rv_lat = 0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h3000;
    d_wstrb = 4'hF;
    d_wdata = 32'h1234_5678;
    smp();
    n_chk++;
    if (d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL zl_dgnt: d_gnt=%b, required 1", d_gnt);
    end
    exp_q.push_back(exp_t'{1'b0, memfn(32'h3000, 1'b0)});
    tick();
    d_req = 1'b0;
    d_we = 1'b1;
    i_req = 1'b1;
    i_addr = 32'h300;
    smp();
    n_chk++;
    if (i_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL zl_gnt_in_req: i_gnt=%b, required 0", i_gnt);
    end
    tick();
    smp();
    n_chk++;
    if ({i_gnt, d_rvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL zl_next_gnt: i_gnt=%b d_rvalid=%b, required 1 1", i_gnt, d_rvalid);
    end
    if (i_gnt) exp_q.push_back(exp_t'{1'b1, memfn(32'h300, 1'b0)});
    tick();
    i_req = 1'b0;
    smp();
    n_chk++;
    if ({m_req, m_addr, m_we, m_wstrb, m_wdata} !== {1'b1, 32'h300, 1'b0, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL zl_iside: m_req=%b addr=%h we=%b strb=%b data=%h, required 1 00000300 0 0000 0",
               m_req, m_addr, m_we, m_wstrb, m_wdata);
    end
    d_we = 1'b0;
    drain("zerolat");
  endtask

  task automatic test_reset_midflight();
    gnt_delay = 0;
    rv_lat = 3;
    i_req = 1'b1;
    i_addr = 32'h100;
    smp();
    n_chk++;
    if (i_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_gnt: i_gnt=%b, required 1", i_gnt);
    end
    tick();
    i_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, m_wstrb,
         m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outs: m_req=%b i_rdata=%h d_rdata=%h, required all 0",
               m_req, i_rdata, d_rdata);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      smp();
      n_chk++;
      if ({i_rvalid, d_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_stale_rv: i_rvalid=%b d_rvalid=%b cycle %0d, required 0 0",
                 i_rvalid, d_rvalid, c);
      end
      tick();
    end
    rv_lat = 1;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h2200;
    smp();
    n_chk++;
    if (d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_after_gnt: d_gnt=%b, required 1", d_gnt);
    end
    exp_q.push_back(exp_t'{1'b0, memfn(32'h2200, 1'b0)});
    tick();
    d_req = 1'b0;
    drain("rst_after");
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_addr = '0;
    d_we = 1'b0;
    d_wstrb = '0;
    d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_burst_order();
    test_write_stall();
    test_zero_latency();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
